// File: rtl/vga_port_pkg.sv
`default_nettype none
// ==========================================================================
// vga_port_pkg : shared command format, FSM encoding and VGA register map
// Rev 1.0
// ==========================================================================
package vga_port_pkg;

  localparam int CMD_W         = 13;
  localparam int CMD_WDATA_LSB = 0;
  localparam int CMD_ADDR_LSB  = 8;
  localparam int CMD_WRITE_BIT = 12;

  localparam logic [7:0] VGA_BASE_ID_DFLT = 8'h10;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_STROBE  = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;

  localparam logic [3:0] VGA_REG_CTRL     = 4'd0;
  localparam logic [3:0] VGA_REG_STATUS   = 4'd1;
  localparam logic [3:0] VGA_REG_CURSOR_X = 4'd2;
  localparam logic [3:0] VGA_REG_CURSOR_Y = 4'd3;
  localparam logic [3:0] VGA_REG_CHAR     = 4'd4;
  localparam logic [3:0] VGA_REG_COLOR    = 4'd5;

  // Field order matches the CMD_* offsets above: {write, addr, wdata}.
  typedef struct packed {
    logic       write;
    logic [3:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  function automatic logic [7:0] port_id_of(input logic [7:0] base, input logic [3:0] addr);
    return base + {4'h0, addr};
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_cmd_fifo.sv
`default_nettype none
// ==========================================================================
// vga_cmd_fifo : FIFO_DEPTH x CMD_W command queue, fall-through read port
// Rev 1.0
// ==========================================================================
module vga_cmd_fifo
  import vga_port_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
)(
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         push,
  input  logic [CMD_W-1:0]             wdata,
  input  logic                         pop,
  output logic [CMD_W-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(FIFO_DEPTH):0]  count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CMD_W-1:0] mem_q [FIFO_DEPTH];
  logic [CMD_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_port_master.sv
`default_nettype none
// ==========================================================================
// vga_port_master : queued register read/write initiator on the VGA port bus
// Rev 1.0
// ==========================================================================
module vga_port_master
  import vga_port_pkg::*;
#(
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] VGA_BASE_ID  = VGA_BASE_ID_DFLT,
  parameter int         READ_LATENCY = 1
)(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic [7:0] Port_ID,
  output logic [7:0] OUT_PORT,
  input  logic [7:0] IN_PORT,
  output logic       CS_VGA,
  output logic       WRITE_STROBE,
  output logic       READ_STROBE,
  output logic       busy
);

  localparam int LAT_W = 3;

  cmd_t                        fifo_wdata;
  cmd_t                        fifo_rdata;
  logic                        fifo_full, fifo_empty, fifo_pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  logic [2:0]       state_q, state_d;
  logic             is_write_q, is_write_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [7:0]       port_id_q, port_id_d;
  logic [7:0]       out_port_q, out_port_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic             cs_q, cs_d;
  logic             wr_stb_q, wr_stb_d;
  logic             rd_stb_q, rd_stb_d;
  logic             rsp_valid_q, rsp_valid_d;

  assign fifo_wdata = '{write: req_write, addr: req_addr, wdata: req_wdata};

  vga_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (req_valid),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Bus outputs are registered and loaded one edge early, so they are valid
  // for the whole cycle of the state they belong to.
  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    lat_d       = lat_q;
    port_id_d   = port_id_q;
    out_port_d  = out_port_q;
    rsp_data_d  = rsp_data_q;
    cs_d        = cs_q;
    wr_stb_d    = 1'b0;
    rd_stb_d    = 1'b0;
    rsp_valid_d = 1'b0;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          is_write_d = fifo_rdata.write;
          cs_d       = 1'b1;
          port_id_d  = port_id_of(VGA_BASE_ID, fifo_rdata.addr);
          if (fifo_rdata.write) begin
            out_port_d = fifo_rdata.wdata;
          end
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        wr_stb_d = is_write_q;
        rd_stb_d = ~is_write_q;
        state_d  = ST_STROBE;
      end
      ST_STROBE: begin
        if (is_write_q) begin
          cs_d    = 1'b0;
          state_d = ST_HOLD;
        end else begin
          lat_d   = LAT_W'(READ_LATENCY);
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q == LAT_W'(1)) begin
          rsp_data_d  = IN_PORT;
          rsp_valid_d = 1'b1;
          cs_d        = 1'b0;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        cs_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      is_write_q  <= 1'b0;
      lat_q       <= '0;
      port_id_q   <= 8'h00;
      out_port_q  <= 8'h00;
      rsp_data_q  <= 8'h00;
      cs_q        <= 1'b0;
      wr_stb_q    <= 1'b0;
      rd_stb_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      lat_q       <= lat_d;
      port_id_q   <= port_id_d;
      out_port_q  <= out_port_d;
      rsp_data_q  <= rsp_data_d;
      cs_q        <= cs_d;
      wr_stb_q    <= wr_stb_d;
      rd_stb_q    <= rd_stb_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready    = RESET & ~fifo_full;
  assign busy         = (fifo_count != '0) | (state_q != ST_IDLE);
  assign Port_ID      = port_id_q;
  assign OUT_PORT     = out_port_q;
  assign CS_VGA       = cs_q;
  assign WRITE_STROBE = wr_stb_q;
  assign READ_STROBE  = rd_stb_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;

endmodule
`default_nettype wire
